aip_responder: RTL and testbench
================================

AIP_RESPONDER -- requirements
Module: aip_responder

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 32, AIP data bus width.
REQ-002 SHALL have parameter SIZE_MEM0, default 32, depth of MEMIN0 and MEMOUT0.
REQ-003 SHALL have parameter SIZE_MEM1, default 64, depth of MEMIN1 and MEMOUT1.
REQ-004 SHALL have parameter IP_ID_VAL, default 32'h0000_1001, constant returned at config 31.
REQ-005 SHALL have one clock and a synchronous, active-low reset, as listed below.
REQ-006 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-007 SHALL have port resetn  in  1  synchronous active-low reset.
REQ-008 SHALL have port conf_dbus  in  5  host register/memory select.
REQ-009 SHALL have port data_in  in  DATAWIDTH  host write data.
REQ-010 SHALL have port write  in  1  host write strobe, one access per cycle high.
REQ-011 SHALL have port read  in  1  host read strobe, one access per cycle high.
REQ-012 SHALL have port start  in  1  host start request.
REQ-013 SHALL have port data_out  out  DATAWIDTH  registered host read data.
REQ-014 SHALL have port int_req  out  1  interrupt to host.
REQ-015 SHALL have port core_start  out  1  one-cycle start pulse to the core.
REQ-016 SHALL have port core_done  in  1  one-cycle done pulse from the core.
REQ-017 SHALL have port memin0_raddr / memin1_raddr  in  log2(SIZE_MEM0) / log2(SIZE_MEM1)  core read addresses.
REQ-018 SHALL have port memin0_rdata / memin1_rdata  out  DATAWIDTH  core read data, registered, 1-cycle latency.
REQ-019 SHALL have port memout0_we, memout0_waddr, memout0_wdata / memout1_*  in  1, log2 depth, DATAWIDTH  core write ports.
REQ-020 SHALL have port conf_regs  out  4*DATAWIDTH  CONFREG words 0..3, word k at bits [32k+:32].

Function
REQ-021 SHALL decode conf_dbus as follows: 0 MMEMIN0, 1 AMEMIN0, 2 MMEMIN1, 3 AMEMIN1, 4 MMEMOUT0, 5 AMEMOUT0, 6 MMEMOUT1, 7 AMEMOUT1, 8 CCONFREG, 9 ACONFREG, 30 STATUS, 31 IP_ID; all other codes unmapped.
REQ-022 SHALL load the pointer with data_in (truncated to its width) on a write to any A* code; reading an A* code SHALL return the pointer zero-extended.
REQ-023 SHALL store data_in at the pointer on a write to MMEMIN0/MMEMIN1/CCONFREG, then post-increment the pointer.
REQ-024 SHALL, on a read of any M* or CCONFREG code, present the word at the pointer on data_out in the next cycle, then post-increment the pointer.
REQ-025 SHALL ignore host writes to MMEMOUT0/MMEMOUT1 (no data or pointer change); host reads of these are allowed.
REQ-026 SHALL wrap pointers modulo depth: 31->0 for MEM0, 63->0 for MEM1, 3->0 for CONFREG.
REQ-027 SHALL hold data_out unchanged in cycles without read; reads of unmapped codes SHALL return 0.
REQ-028 SHALL treat write as winning when read and write are both high (read ignored, no pointer change from the read).
REQ-029 SHALL format STATUS as [31:24]=0, [23:16]=int mask, [15:9]=0, [8]=busy, [7:0]=int flags.
REQ-030 SHALL, on a STATUS write, load mask from data_in[23:16] and clear every flag whose data_in[7:0] bit is 1.
REQ-031 SHALL set flag[0] and clear busy on core_done; set SHALL win over a same-cycle clear.
REQ-032 SHALL drive int_req = |(flags & mask) combinationally from registers.
REQ-033 SHALL run a two-state FSM IDLE/BUSY: start in IDLE -> core_start high for exactly the next cycle, BUSY; core_done in BUSY -> IDLE.
REQ-034 SHALL ignore start while BUSY, and SHALL ignore core_done while IDLE except for setting flag[0].
REQ-035 SHALL make core write data readable by the host in the cycle after memout*_we; host and core ports SHALL be independent.

Reset
REQ-036 SHALL, while resetn is low at a clock edge, clear pointers, mask, flags, CONFREG words, data_out, core_start and int_req to 0, and set the FSM to IDLE; memory contents are undefined after reset, and a reset mid-BUSY aborts to IDLE.

Verification
REQ-037 SHALL pass: read conf 31 -> data_out = 32'h0000_1001 one cycle after read.
REQ-038 SHALL pass: AMEMIN0 <- 30, write 4 words A,B,C,D to MMEMIN0 -> core reads addr 30,31,0,1 = A,B,C,D; AMEMIN0 reads back 2.
REQ-039 SHALL pass: STATUS <- 32'h0001_0000, start, core_done after 10 cycles -> core_start single pulse, int_req = 1, STATUS = 32'h0001_0001.
REQ-040 SHALL pass: STATUS <- 32'h0001_0001 in the same cycle as core_done -> flag[0] stays 1.
REQ-041 SHALL pass: ACONFREG <- 3, write 11,12 to CCONFREG -> conf_regs word3 = 11, word0 = 12.
REQ-042 SHALL pass: start pulsed twice while BUSY -> one core_start only; resetn low mid-BUSY -> IDLE, all outputs 0.

Source files
------------

// File: rtl/aip_responder.sv
// rtl/aip_responder.sv - AIP host register/memory responder with core start/done handshake
//
// Host side: conf_dbus selects a register or memory, write/read strobes perform
// one access per cycle, data_out is registered. Memory (M*) and CCONFREG
// accesses use an auto-incrementing pointer loaded through the matching A* code.
// Core side: memin0/memin1 read ports (1-cycle latency), memout0/memout1 write
// ports, core_start pulse out, core_done pulse in, conf_regs exposes CONFREG.
// Status: int_req = |(flags & mask); STATUS = {0, mask, 0, busy, flags}.

module aip_responder #(
    parameter int          DATAWIDTH = 32,
    parameter int          SIZE_MEM0 = 32,
    parameter int          SIZE_MEM1 = 64,
    parameter logic [31:0] IP_ID_VAL = 32'h0000_1001,
    localparam int         AW0       = $clog2(SIZE_MEM0),
    localparam int         AW1       = $clog2(SIZE_MEM1)
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [4:0]             conf_dbus,
    input  logic [DATAWIDTH-1:0]   data_in,
    input  logic                   write,
    input  logic                   read,
    input  logic                   start,
    output logic [DATAWIDTH-1:0]   data_out,
    output logic                   int_req,
    output logic                   core_start,
    input  logic                   core_done,
    input  logic [AW0-1:0]         memin0_raddr,
    input  logic [AW1-1:0]         memin1_raddr,
    output logic [DATAWIDTH-1:0]   memin0_rdata,
    output logic [DATAWIDTH-1:0]   memin1_rdata,
    input  logic                   memout0_we,
    input  logic [AW0-1:0]         memout0_waddr,
    input  logic [DATAWIDTH-1:0]   memout0_wdata,
    input  logic                   memout1_we,
    input  logic [AW1-1:0]         memout1_waddr,
    input  logic [DATAWIDTH-1:0]   memout1_wdata,
    output logic [4*DATAWIDTH-1:0] conf_regs
);

    localparam logic [4:0] C_MMEMIN0  = 5'd0;
    localparam logic [4:0] C_AMEMIN0  = 5'd1;
    localparam logic [4:0] C_MMEMIN1  = 5'd2;
    localparam logic [4:0] C_AMEMIN1  = 5'd3;
    localparam logic [4:0] C_MMEMOUT0 = 5'd4;
    localparam logic [4:0] C_AMEMOUT0 = 5'd5;
    localparam logic [4:0] C_MMEMOUT1 = 5'd6;
    localparam logic [4:0] C_AMEMOUT1 = 5'd7;
    localparam logic [4:0] C_CCONFREG = 5'd8;
    localparam logic [4:0] C_ACONFREG = 5'd9;
    localparam logic [4:0] C_STATUS   = 5'd30;
    localparam logic [4:0] C_IP_ID    = 5'd31;

    typedef enum logic {S_IDLE, S_BUSY} state_e;

    logic [DATAWIDTH-1:0] memin0_q  [SIZE_MEM0];
    logic [DATAWIDTH-1:0] memin1_q  [SIZE_MEM1];
    logic [DATAWIDTH-1:0] memout0_q [SIZE_MEM0];
    logic [DATAWIDTH-1:0] memout1_q [SIZE_MEM1];
    logic [DATAWIDTH-1:0] conf_q    [4];

    logic [AW0-1:0]       ptr_min0_q;
    logic [AW1-1:0]       ptr_min1_q;
    logic [AW0-1:0]       ptr_mout0_q;
    logic [AW1-1:0]       ptr_mout1_q;
    logic [1:0]           ptr_conf_q;
    logic [7:0]           mask_q;
    logic [7:0]           flags_q;
    logic [DATAWIDTH-1:0] data_out_q;
    logic                 core_start_q;
    state_e               state_q;
    logic [31:0]          status_w;

    assign status_w   = {8'h00, mask_q, 7'h00, (state_q == S_BUSY), flags_q};
    assign int_req    = |(flags_q & mask_q);
    assign data_out   = data_out_q;
    assign core_start = core_start_q;

    for (genvar k = 0; k < 4; k++) begin : g_conf
        assign conf_regs[k*DATAWIDTH +: DATAWIDTH] = conf_q[k];
    end

    // Memory arrays carry no reset; host-side writes use the pre-increment pointer.
    always_ff @(posedge clk) begin
        if (write && conf_dbus == C_MMEMIN0) memin0_q[ptr_min0_q] <= data_in;
        if (write && conf_dbus == C_MMEMIN1) memin1_q[ptr_min1_q] <= data_in;
        if (memout0_we) memout0_q[memout0_waddr] <= memout0_wdata;
        if (memout1_we) memout1_q[memout1_waddr] <= memout1_wdata;
        memin0_rdata <= memin0_q[memin0_raddr];
        memin1_rdata <= memin1_q[memin1_raddr];
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ptr_min0_q   <= '0;
            ptr_min1_q   <= '0;
            ptr_mout0_q  <= '0;
            ptr_mout1_q  <= '0;
            ptr_conf_q   <= '0;
            mask_q       <= '0;
            flags_q      <= '0;
            data_out_q   <= '0;
            core_start_q <= 1'b0;
            state_q      <= S_IDLE;
            for (int k = 0; k < 4; k++) conf_q[k] <= '0;
        end else begin
            core_start_q <= 1'b0;
            case (state_q)
                S_IDLE: if (start) begin
                    state_q      <= S_BUSY;
                    core_start_q <= 1'b1;
                end
                S_BUSY: if (core_done) state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase

            // Write has priority; a simultaneous read is dropped entirely.
            if (write) begin
                case (conf_dbus)
                    C_AMEMIN0:  ptr_min0_q  <= data_in[AW0-1:0];
                    C_AMEMIN1:  ptr_min1_q  <= data_in[AW1-1:0];
                    C_AMEMOUT0: ptr_mout0_q <= data_in[AW0-1:0];
                    C_AMEMOUT1: ptr_mout1_q <= data_in[AW1-1:0];
                    C_ACONFREG: ptr_conf_q  <= data_in[1:0];
                    C_MMEMIN0:  ptr_min0_q  <= ptr_min0_q + AW0'(1);
                    C_MMEMIN1:  ptr_min1_q  <= ptr_min1_q + AW1'(1);
                    C_CCONFREG: begin
                        conf_q[ptr_conf_q] <= data_in;
                        ptr_conf_q         <= ptr_conf_q + 2'd1;
                    end
                    C_STATUS: begin
                        mask_q  <= data_in[23:16];
                        flags_q <= flags_q & ~data_in[7:0];
                    end
                    default: ;
                endcase
            end else if (read) begin
                case (conf_dbus)
                    C_MMEMIN0: begin
                        data_out_q <= memin0_q[ptr_min0_q];
                        ptr_min0_q <= ptr_min0_q + AW0'(1);
                    end
                    C_MMEMIN1: begin
                        data_out_q <= memin1_q[ptr_min1_q];
                        ptr_min1_q <= ptr_min1_q + AW1'(1);
                    end
                    C_MMEMOUT0: begin
                        data_out_q  <= memout0_q[ptr_mout0_q];
                        ptr_mout0_q <= ptr_mout0_q + AW0'(1);
                    end
                    C_MMEMOUT1: begin
                        data_out_q  <= memout1_q[ptr_mout1_q];
                        ptr_mout1_q <= ptr_mout1_q + AW1'(1);
                    end
                    C_CCONFREG: begin
                        data_out_q <= conf_q[ptr_conf_q];
                        ptr_conf_q <= ptr_conf_q + 2'd1;
                    end
                    C_AMEMIN0:  data_out_q <= DATAWIDTH'(ptr_min0_q);
                    C_AMEMIN1:  data_out_q <= DATAWIDTH'(ptr_min1_q);
                    C_AMEMOUT0: data_out_q <= DATAWIDTH'(ptr_mout0_q);
                    C_AMEMOUT1: data_out_q <= DATAWIDTH'(ptr_mout1_q);
                    C_ACONFREG: data_out_q <= DATAWIDTH'(ptr_conf_q);
                    C_STATUS:   data_out_q <= DATAWIDTH'(status_w);
                    C_IP_ID:    data_out_q <= DATAWIDTH'(IP_ID_VAL);
                    default:    data_out_q <= '0;
                endcase
            end

            // Placed last so a done-driven set overrides a same-cycle host clear.
            if (core_done) flags_q[0] <= 1'b1;
        end
    end

endmodule

// File: tb/tb_aip_responder.sv
// tb/tb_aip_responder.sv - self-checking bench for aip_responder
module tb_aip_responder;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic [4:0]   conf_dbus = '0;
    logic [31:0]  data_in = '0;
    logic         write = 1'b0;
    logic         read = 1'b0;
    logic         start = 1'b0;
    logic [31:0]  data_out;
    logic         int_req;
    logic         core_start;
    logic         core_done = 1'b0;
    logic [4:0]   memin0_raddr = '0;
    logic [5:0]   memin1_raddr = '0;
    logic [31:0]  memin0_rdata;
    logic [31:0]  memin1_rdata;
    logic         memout0_we = 1'b0;
    logic [4:0]   memout0_waddr = '0;
    logic [31:0]  memout0_wdata = '0;
    logic         memout1_we = 1'b0;
    logic [5:0]   memout1_waddr = '0;
    logic [31:0]  memout1_wdata = '0;
    logic [127:0] conf_regs;

    int total = 0;
    int bad = 0;

    aip_responder dut (
        .clk(clk), .resetn(resetn), .conf_dbus(conf_dbus), .data_in(data_in),
        .write(write), .read(read), .start(start), .data_out(data_out),
        .int_req(int_req), .core_start(core_start), .core_done(core_done),
        .memin0_raddr(memin0_raddr), .memin1_raddr(memin1_raddr),
        .memin0_rdata(memin0_rdata), .memin1_rdata(memin1_rdata),
        .memout0_we(memout0_we), .memout0_waddr(memout0_waddr), .memout0_wdata(memout0_wdata),
        .memout1_we(memout1_we), .memout1_waddr(memout1_waddr), .memout1_wdata(memout1_wdata),
        .conf_regs(conf_regs)
    );

    always #5 clk = ~clk;

    // Reference model: index 0 MEMIN0, 1 MEMIN1, 2 MEMOUT0, 3 MEMOUT1, 4 CONFREG.
    logic [31:0] m_mem [5][64];
    int          m_ptr [5];
    int          m_depth [5] = '{32, 64, 32, 64, 4};
    logic [7:0]  m_mask;
    logic [7:0]  m_flags;
    logic        m_busy;
    logic [31:0] m_dout;
    logic        m_cs;
    logic [31:0] m_cr0;
    logic [31:0] m_cr1;

    function automatic logic [127:0] m_conf_vec();
        return {m_mem[4][3], m_mem[4][2], m_mem[4][1], m_mem[4][0]};
    endfunction

    function automatic logic m_irq();
        return |(m_flags & m_mask);
    endfunction

    task automatic step(input bit w, input bit r, input logic [4:0] c,
                        input logic [31:0] d, input bit st, input bit dn);
        int idx;
        write = w; read = r; conf_dbus = c; data_in = d; start = st; core_done = dn;
        m_cr0 = m_mem[0][memin0_raddr];
        m_cr1 = m_mem[1][memin1_raddr];
        idx = int'(c) / 2;
        if (w) begin
            if (c <= 5'd9) begin
                if (c[0]) m_ptr[idx] = int'(d % 32'(m_depth[idx]));
                else if (idx == 0 || idx == 1 || idx == 4) begin
                    m_mem[idx][m_ptr[idx]] = d;
                    m_ptr[idx] = (m_ptr[idx] + 1) % m_depth[idx];
                end
            end else if (c == 5'd30) begin
                m_mask  = d[23:16];
                m_flags = m_flags & ~d[7:0];
            end
        end else if (r) begin
            if (c <= 5'd9) begin
                if (c[0]) m_dout = 32'(m_ptr[idx]);
                else begin
                    m_dout = m_mem[idx][m_ptr[idx]];
                    m_ptr[idx] = (m_ptr[idx] + 1) % m_depth[idx];
                end
            end else if (c == 5'd30) m_dout = {8'h00, m_mask, 7'h00, m_busy, m_flags};
            else if (c == 5'd31) m_dout = 32'h0000_1001;
            else m_dout = '0;
        end
        if (memout0_we) m_mem[2][memout0_waddr] = memout0_wdata;
        if (memout1_we) m_mem[3][memout1_waddr] = memout1_wdata;
        m_cs = st && !m_busy;
        if (st && !m_busy) m_busy = 1'b1;
        else if (dn && m_busy) m_busy = 1'b0;
        if (dn) m_flags[0] = 1'b1;
        @(posedge clk); #1;
        write = 0; read = 0; start = 0; core_done = 0; memout0_we = 0; memout1_we = 0;
    endtask

    task automatic apply_reset();
        resetn = 1'b0; write = 0; read = 0; start = 0; core_done = 0;
        memout0_we = 0; memout1_we = 0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        for (int i = 0; i < 5; i++) m_ptr[i] = 0;
        for (int i = 0; i < 4; i++) m_mem[4][i] = '0;
        m_mask = '0; m_flags = '0; m_busy = 1'b0; m_dout = '0; m_cs = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        total++; if (data_out !== 32'h0) begin bad++; $display("FAIL reset_dout got=%h exp=0", data_out); end
        total++; if (core_start !== 1'b0) begin bad++; $display("FAIL reset_core_start got=%b exp=0", core_start); end
        total++; if (int_req !== 1'b0) begin bad++; $display("FAIL reset_int_req got=%b exp=0", int_req); end
        total++; if (conf_regs !== 128'h0) begin bad++; $display("FAIL reset_conf_regs got=%h exp=0", conf_regs); end
        step(0, 1, 5'd30, 0, 0, 0);
        total++; if (data_out !== 32'h0) begin bad++; $display("FAIL reset_status got=%h exp=0", data_out); end
        for (int c = 1; c <= 9; c += 2) begin
            step(0, 1, 5'(c), 0, 0, 0);
            total++; if (data_out !== 32'h0) begin bad++; $display("FAIL reset_ptr%0d got=%h exp=0", c, data_out); end
        end
    endtask

    task automatic test_ip_id();
        step(0, 1, 5'd31, 0, 0, 0);
        total++; if (data_out !== 32'h0000_1001) begin bad++; $display("FAIL ip_id got=%h exp=00001001", data_out); end
        step(0, 0, 5'd12, 32'hFFFF_FFFF, 0, 0);
        total++; if (data_out !== 32'h0000_1001) begin bad++; $display("FAIL dout_hold got=%h exp=00001001", data_out); end
        step(0, 1, 5'd12, 0, 0, 0);
        total++; if (data_out !== 32'h0) begin bad++; $display("FAIL unmapped_read got=%h exp=0", data_out); end
    endtask

    task automatic test_memin0_wrap();
        logic [31:0] words [4] = '{32'hA0A0_000A, 32'hB0B0_000B, 32'hC0C0_000C, 32'hD0D0_000D};
        logic [4:0]  addrs [4] = '{5'd30, 5'd31, 5'd0, 5'd1};
        step(1, 0, 5'd1, 32'd30, 0, 0);
        for (int k = 0; k < 4; k++) step(1, 0, 5'd0, words[k], 0, 0);
        for (int k = 0; k < 4; k++) begin
            memin0_raddr = addrs[k];
            step(0, 0, 5'd0, 0, 0, 0);
            total++;
            if (memin0_rdata !== words[k]) begin
                bad++; $display("FAIL memin0_core_read addr=%0d got=%h exp=%h", addrs[k], memin0_rdata, words[k]);
            end
        end
        step(0, 1, 5'd1, 0, 0, 0);
        total++; if (data_out !== 32'd2) begin bad++; $display("FAIL amemin0_wrap got=%h exp=2", data_out); end
    endtask

    task automatic test_core_write();
        logic [31:0] v;
        v = $urandom;
        step(1, 0, 5'd5, 32'd7, 0, 0);
        memout0_we = 1; memout0_waddr = 5'd7; memout0_wdata = v;
        step(0, 0, 5'd0, 0, 0, 0);
        step(0, 1, 5'd4, 0, 0, 0);
        total++; if (data_out !== v) begin bad++; $display("FAIL memout0_readback got=%h exp=%h", data_out, v); end
        step(1, 0, 5'd4, ~v, 0, 0);
        step(0, 1, 5'd5, 0, 0, 0);
        total++; if (data_out !== 32'd8) begin bad++; $display("FAIL memout0_write_ignored got=%h exp=8", data_out); end
    endtask

    task automatic test_conf();
        step(1, 0, 5'd9, 32'd3, 0, 0);
        step(1, 0, 5'd8, 32'd11, 0, 0);
        step(1, 0, 5'd8, 32'd12, 0, 0);
        total++; if (conf_regs[96 +: 32] !== 32'd11) begin bad++; $display("FAIL conf_word3 got=%h exp=b", conf_regs[96 +: 32]); end
        total++; if (conf_regs[0 +: 32] !== 32'd12) begin bad++; $display("FAIL conf_word0 got=%h exp=c", conf_regs[0 +: 32]); end
        step(1, 0, 5'd9, 32'd3, 0, 0);
        step(0, 1, 5'd8, 0, 0, 0);
        total++; if (data_out !== 32'd11) begin bad++; $display("FAIL conf_read got=%h exp=b", data_out); end
    endtask

    task automatic test_status_irq();
        int pulses;
        apply_reset();
        step(1, 0, 5'd30, 32'h0001_0000, 0, 0);
        step(0, 0, 5'd0, 0, 1, 0);
        pulses = (core_start === 1'b1) ? 1 : 0;
        total++; if (core_start !== 1'b1) begin bad++; $display("FAIL core_start_rise got=%b exp=1", core_start); end
        step(0, 1, 5'd30, 0, 0, 0);
        if (core_start === 1'b1) pulses++;
        total++; if (data_out !== 32'h0001_0100) begin bad++; $display("FAIL status_busy got=%h exp=00010100", data_out); end
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 5'd0, 0, 0, 0);
            if (core_start === 1'b1) pulses++;
        end
        step(0, 0, 5'd0, 0, 0, 1);
        if (core_start === 1'b1) pulses++;
        total++; if (pulses != 1) begin bad++; $display("FAIL core_start_pulses got=%0d exp=1", pulses); end
        total++; if (int_req !== 1'b1) begin bad++; $display("FAIL int_req_done got=%b exp=1", int_req); end
        step(0, 1, 5'd30, 0, 0, 0);
        total++; if (data_out !== 32'h0001_0001) begin bad++; $display("FAIL status_done got=%h exp=00010001", data_out); end
    endtask

    task automatic test_done_vs_clear();
        step(0, 0, 5'd0, 0, 1, 0);
        step(0, 0, 5'd0, 0, 0, 0);
        step(1, 0, 5'd30, 32'h0001_0001, 0, 1);
        total++; if (int_req !== 1'b1) begin bad++; $display("FAIL set_wins_irq got=%b exp=1", int_req); end
        step(0, 1, 5'd30, 0, 0, 0);
        total++; if (data_out !== 32'h0001_0001) begin bad++; $display("FAIL set_wins_status got=%h exp=00010001", data_out); end
        step(1, 0, 5'd30, 32'h0001_0001, 0, 0);
        total++; if (int_req !== 1'b0) begin bad++; $display("FAIL clear_irq got=%b exp=0", int_req); end
        step(0, 1, 5'd30, 0, 0, 0);
        total++; if (data_out !== 32'h0001_0000) begin bad++; $display("FAIL clear_status got=%h exp=00010000", data_out); end
    endtask

    task automatic test_back_to_back_start_reset();
        int pulses = 0;
        step(0, 0, 5'd0, 0, 1, 0);
        if (core_start === 1'b1) pulses++;
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 5'd0, 0, (i % 2 == 0), 0);
            if (core_start === 1'b1) pulses++;
        end
        total++; if (pulses != 1) begin bad++; $display("FAIL busy_start_ignored pulses=%0d exp=1", pulses); end
        apply_reset();
        total++; if ({data_out, int_req, core_start} !== 34'h0) begin
            bad++; $display("FAIL reset_mid_busy got=%h/%b/%b exp=0/0/0", data_out, int_req, core_start);
        end
        step(0, 1, 5'd30, 0, 0, 0);
        total++; if (data_out !== 32'h0) begin bad++; $display("FAIL reset_mid_busy_status got=%h exp=0", data_out); end
        step(0, 0, 5'd0, 0, 1, 0);
        total++; if (core_start !== 1'b1) begin bad++; $display("FAIL start_after_reset got=%b exp=1", core_start); end
        step(0, 0, 5'd0, 0, 0, 1);
    endtask

    task automatic test_random();
        logic [4:0] c;
        int sel;
        apply_reset();
        step(1, 0, 5'd1, 0, 0, 0);
        for (int i = 0; i < 32; i++) step(1, 0, 5'd0, $urandom, 0, 0);
        step(1, 0, 5'd3, 0, 0, 0);
        for (int i = 0; i < 64; i++) step(1, 0, 5'd2, $urandom, 0, 0);
        for (int i = 0; i < 64; i++) begin
            memout0_we = 1; memout0_waddr = 5'(i); memout0_wdata = $urandom;
            memout1_we = 1; memout1_waddr = 6'(i); memout1_wdata = $urandom;
            step(0, 0, 5'd0, 0, 0, 0);
        end
        for (int i = 0; i < 400; i++) begin
            sel = $urandom_range(0, 15);
            if (sel < 10) c = 5'(sel);
            else if (sel < 12) c = 5'd30;
            else if (sel == 12) c = 5'd31;
            else c = 5'($urandom_range(10, 29));
            memin0_raddr = 5'($urandom_range(0, 31));
            memin1_raddr = 6'($urandom_range(0, 63));
            memout0_we = ($urandom_range(0, 3) == 0);
            memout0_waddr = 5'($urandom_range(0, 31));
            memout0_wdata = $urandom;
            memout1_we = ($urandom_range(0, 3) == 0);
            memout1_waddr = 6'($urandom_range(0, 63));
            memout1_wdata = $urandom;
            step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, c, $urandom,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
            total++; if (data_out !== m_dout) begin bad++; $display("FAIL rnd_dout it=%0d code=%0d got=%h exp=%h", i, c, data_out, m_dout); end
            total++; if (core_start !== m_cs) begin bad++; $display("FAIL rnd_core_start it=%0d got=%b exp=%b", i, core_start, m_cs); end
            total++; if (int_req !== m_irq()) begin bad++; $display("FAIL rnd_int_req it=%0d got=%b exp=%b", i, int_req, m_irq()); end
            total++; if (conf_regs !== m_conf_vec()) begin bad++; $display("FAIL rnd_conf_regs it=%0d got=%h exp=%h", i, conf_regs, m_conf_vec()); end
            total++; if (memin0_rdata !== m_cr0) begin bad++; $display("FAIL rnd_memin0 it=%0d got=%h exp=%h", i, memin0_rdata, m_cr0); end
            total++; if (memin1_rdata !== m_cr1) begin bad++; $display("FAIL rnd_memin1 it=%0d got=%h exp=%h", i, memin1_rdata, m_cr1); end
        end
    endtask

    initial begin
        test_reset();
        test_ip_id();
        test_memin0_wrap();
        test_core_write();
        test_conf();
        test_status_irq();
        test_done_vs_clear();
        test_back_to_back_start_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
